branch_target_predictor: RTL and testbench

Parametrised branch target buffer with 2-bit saturating direction counters for the IF stage of the 5-stage pipeline. It replaces always-not-taken fetch with predicted-taken fetch. IF looks up the current PC combinationally and gets a predicted next PC in the same cycle. ID returns one resolution per cycle, which trains the table and counts mispredictions.

---
 rtl/branch_target_predictor.sv | 84 ++++++++
 tb/tb_branch_target_predictor.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with 2-bit direction counters for IF.
// Lookup is combinational from pre-edge state; ID resolutions train it one per cycle.
module branch_target_predictor #(
  parameter int          ADDR_W   = 32,
  parameter int          ENTRIES  = 16,
  parameter logic [1:0]  CNT_INIT = 2'b01,
  parameter int          STAT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] lookup_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_mispredict,
  input  logic              clear,
  output logic [STAT_W-1:0] stat_updates,
  output logic [STAT_W-1:0] stat_mispredicts
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  logic [ENTRIES-1:0]             valid;
  logic [ENTRIES-1:0][TAG_W-1:0]  tagArr;
  logic [ENTRIES-1:0][ADDR_W-1:0] targetArr;
  logic [ENTRIES-1:0][1:0]        ctr;

  logic [IDX_W-1:0] lkIdx, updIdx;
  logic [TAG_W-1:0] lkTag, updTag;
  logic             updHit;

  assign lkIdx  = lookup_pc[IDX_W+1:2];
  assign lkTag  = lookup_pc[ADDR_W-1:IDX_W+2];
  assign updIdx = upd_pc[IDX_W+1:2];
  assign updTag = upd_pc[ADDR_W-1:IDX_W+2];

  assign pred_hit    = valid[lkIdx] && (tagArr[lkIdx] == lkTag);
  assign pred_taken  = pred_hit && ctr[lkIdx][1];
  assign pred_target = pred_taken ? targetArr[lkIdx] : lookup_pc + ADDR_W'(4);

  assign updHit = valid[updIdx] && (tagArr[updIdx] == updTag);

  // clear wins over any same-cycle training; ctr/target are left stale on clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid     <= '0;
      ctr       <= {ENTRIES{CNT_INIT}};
      tagArr    <= '0;
      targetArr <= '0;
    end else if (clear) begin
      valid <= '0;
    end else if (upd_valid) begin
      if (updHit) begin
        if (upd_taken) begin
          if (ctr[updIdx] != 2'b11) ctr[updIdx] <= ctr[updIdx] + 2'd1;
          targetArr[updIdx] <= upd_target;
        end else if (ctr[updIdx] != 2'b00) begin
          ctr[updIdx] <= ctr[updIdx] - 2'd1;
        end
      end else if (upd_taken) begin
        valid[updIdx]     <= 1'b1;
        tagArr[updIdx]    <= updTag;
        targetArr[updIdx] <= upd_target;
        ctr[updIdx]       <= 2'b10;
      end
    end
  end

  // statistics saturate and survive clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_updates     <= '0;
      stat_mispredicts <= '0;
    end else if (upd_valid) begin
      if (stat_updates != '1) stat_updates <= stat_updates + STAT_W'(1);
      if (upd_mispredict && stat_mispredicts != '1)
        stat_mispredicts <= stat_mispredicts + STAT_W'(1);
    end
  end
endmodule

// File: tb/tb_branch_target_predictor.sv
// Scoreboard bench: driver pushes model-predicted outputs, negedge monitor pops and compares.
module tb_branch_target_predictor;
  localparam int AW = 32, EN = 16, SW = 4, IW = 4;
  localparam int SMAX = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] lookup_pc, upd_pc, upd_target, pred_target;
  logic          upd_valid, upd_taken, upd_mispredict, clear;
  logic          pred_hit, pred_taken;
  logic [SW-1:0] stat_updates, stat_mispredicts;

  branch_target_predictor #(.ADDR_W(AW), .ENTRIES(EN), .CNT_INIT(2'b01), .STAT_W(SW)) dut (
    .clk(clk), .reset(reset), .lookup_pc(lookup_pc), .pred_hit(pred_hit),
    .pred_taken(pred_taken), .pred_target(pred_target), .upd_valid(upd_valid),
    .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_mispredict(upd_mispredict), .clear(clear), .stat_updates(stat_updates),
    .stat_mispredicts(stat_mispredicts));

  always #5 clk = ~clk;

  typedef struct { bit hit; bit taken; logic [AW-1:0] tgt; int su; int sm; } exp_t;
  exp_t q[$];
  int nChk = 0, nPass = 0;

  // reference model: table as plain arrays of ints indexed by pc slot
  bit            mV[EN];
  int unsigned   mTag[EN];
  logic [AW-1:0] mTgt[EN];
  int            mCtr[EN];
  int            mSu, mSm;

  function automatic int idxOf(logic [AW-1:0] pc);
    return int'((pc >> 2) % EN);
  endfunction
  function automatic int unsigned tagOf(logic [AW-1:0] pc);
    return pc >> (IW + 2);
  endfunction

  task automatic modelReset();
    for (int i = 0; i < EN; i++) begin
      mV[i] = 0; mTag[i] = 0; mTgt[i] = '0; mCtr[i] = 1;
    end
    mSu = 0; mSm = 0;
  endtask

  function automatic exp_t predict(logic [AW-1:0] pc);
    exp_t e;
    int i = idxOf(pc);
    e.hit   = mV[i] && (mTag[i] == tagOf(pc));
    e.taken = e.hit && (mCtr[i] >= 2);
    e.tgt   = e.taken ? mTgt[i] : pc + 32'd4;
    e.su    = mSu;
    e.sm    = mSm;
    return e;
  endfunction

  task automatic modelEdge();
    int i;
    bit hit;
    if (upd_valid) begin
      if (mSu < SMAX) mSu++;
      if (upd_mispredict && mSm < SMAX) mSm++;
    end
    if (clear) begin
      for (int k = 0; k < EN; k++) mV[k] = 0;
    end else if (upd_valid) begin
      i   = idxOf(upd_pc);
      hit = mV[i] && (mTag[i] == tagOf(upd_pc));
      if (hit && upd_taken) begin
        mCtr[i] = (mCtr[i] < 3) ? mCtr[i] + 1 : 3;
        mTgt[i] = upd_target;
      end else if (hit) begin
        mCtr[i] = (mCtr[i] > 0) ? mCtr[i] - 1 : 0;
      end else if (upd_taken) begin
        mV[i] = 1; mTag[i] = tagOf(upd_pc); mTgt[i] = upd_target; mCtr[i] = 2;
      end
    end
  endtask

  // one cycle: inputs driven just after a posedge, checked at the following negedge
  task automatic cyc(input logic [AW-1:0] lpc, input bit uv, input logic [AW-1:0] upc,
                     input bit ut, input logic [AW-1:0] utgt, input bit um,
                     input bit clr, input bit midReset);
    lookup_pc = lpc; upd_valid = uv; upd_pc = upc; upd_taken = ut;
    upd_target = utgt; upd_mispredict = um; clear = clr;
    if (midReset) begin
      reset = 1'b0;
      modelReset();
    end
    q.push_back(predict(lpc));
    @(posedge clk);
    if (!midReset) modelEdge();
    #1;
    reset = 1'b1;
  endtask

  task automatic look(input logic [AW-1:0] lpc);
    cyc(lpc, 0, '0, 0, '0, 0, 0, 0);
  endtask
  task automatic upd(input logic [AW-1:0] lpc, input logic [AW-1:0] upc, input bit ut,
                     input logic [AW-1:0] utgt);
    cyc(lpc, 1, upc, ut, utgt, 0, 0, 0);
  endtask

  function automatic logic [AW-1:0] rpc();
    logic [AW-1:0] p;
    p = $urandom;
    if ($urandom_range(0, 3) != 0) p[AW-1:IW+2] = 26'($urandom_range(0, 3));
    return p;
  endfunction

  task automatic chk(input string nm, input logic [AW-1:0] act, input logic [AW-1:0] want);
    nChk++;
    if (act === want) nPass++;
    else $display("FAIL %s: got %h want %h (t=%0t)", nm, act, want, $time);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pred_hit", 32'(pred_hit), 32'(e.hit));
        chk("pred_taken", 32'(pred_taken), 32'(e.taken));
        chk("pred_target", pred_target, e.tgt);
        chk("stat_updates", 32'(stat_updates), 32'(e.su));
        chk("stat_mispredicts", 32'(stat_mispredicts), 32'(e.sm));
      end
    end
  end

  initial begin : driver
    reset = 1'b0; lookup_pc = '0; upd_valid = 0; upd_pc = '0; upd_taken = 0;
    upd_target = '0; upd_mispredict = 0; clear = 0;
    modelReset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    look(32'h40);
    look(32'hFFFF_FFFC);
    upd(32'h40, 32'h40, 1, 32'h100);
    look(32'h40);
    upd(32'h40, 32'h40, 0, 32'h0);
    look(32'h40);
    repeat (3) upd(32'h40, 32'h40, 1, 32'h100);
    look(32'h40);
    upd(32'h40, 32'h40, 0, 32'h0);
    look(32'h40);
    upd(32'h40, 32'h80, 1, 32'h200);
    look(32'h40);
    look(32'h80);
    upd(32'h80, 32'hC0, 0, 32'h300);
    look(32'h80);
    cyc(32'h40, 1, 32'h40, 1, 32'h100, 0, 1, 0);
    look(32'h40);
    look(32'h80);
    for (int i = 0; i < 20; i++)
      cyc(32'h40, 1, rpc(), 1'($urandom), $urandom, 1, 0, 0);
    look(32'h40);
    cyc(32'h80, 1, 32'h80, 1, 32'h500, 1, 0, 1);
    look(32'h80);

    for (int i = 0; i < 400; i++) begin
      cyc(rpc(), $urandom_range(0, 3) != 0, rpc(), 1'($urandom), $urandom,
          1'($urandom), $urandom_range(0, 19) == 0, $urandom_range(0, 49) == 0);
    end

    @(negedge clk);
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      nChk++;
      $display("FAIL scoreboard_drain: got %0d left want 0", q.size());
    end
    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end
endmodule
